// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks an N_IN-bit vector through all 2^N_IN values, samples the block-under-test output and scores it against EXPECTED.
// Latency: done rises 2^N_IN*HOLD clocks after the start edge. The sample for each vector is taken on its last hold clock.
// Backpressure: none. A start seen while busy is ignored, and a start in IDLE or DONE launches a fresh sweep.
//
// Ports: clk/rst (async active-high) | start -> begin sweep | vec_out -> DUT inputs (MSB = 'a')
//        f_in <- DUT output | busy, done, pass, err_count, err_seen, first_err_idx, mism -> status
// Optional build macro SWEEP_GRAY_EN: vectors are driven in Gray-code order instead of binary order.
module truth_table_sweeper #(
    parameter int          N_IN     = 4,
    parameter int          HOLD     = 20,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic              f_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              err_seen,
    output logic [N_IN-1:0]   first_err_idx,
    output logic              mism
);
    localparam int                NV        = 1 << N_IN;
    localparam int                HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [NV-1:0]     EXP_TBL   = EXPECTED[NV-1:0];
    localparam logic [N_IN-1:0]   LAST_IDX  = N_IN'(NV - 1);
    localparam logic [HW-1:0]     LAST_HOLD = HW'(HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [HW-1:0]     hold_q;
    logic [N_IN-1:0]   vec_q;
    logic [N_IN:0]     err_cnt_q;
    logic              err_seen_q;
    logic [N_IN-1:0]   first_q;
    logic              mism_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic [N_IN-1:0]   idx_d;
    logic [N_IN-1:0]   vec_d;
    logic              sample;
    logic              miss;
    logic [N_IN:0]     err_cnt_d;

    always_comb begin
        idx_d = idx_q + 1'b1;
`ifdef SWEEP_GRAY_EN
        vec_d = idx_d ^ (idx_d >> 1);
`else
        vec_d = idx_d;
`endif
        // Only the last clock of each hold window is scored, so earlier glitches on f_in are ignored.
        sample    = (state_q == S_DRIVE) && (hold_q == LAST_HOLD);
        // The expected bit is looked up by the driven vector value, not by the step index.
        miss      = sample && (f_in != EXP_TBL[vec_q]);
        err_cnt_d = err_cnt_q + (N_IN+1)'(miss);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            vec_q      <= '0;
            err_cnt_q  <= '0;
            err_seen_q <= 1'b0;
            first_q    <= '0;
            mism_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            mism_q <= miss;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_DRIVE;
                        idx_q      <= '0;
                        hold_q     <= '0;
                        vec_q      <= '0;   // step 0 is vector 0 in both orders
                        err_cnt_q  <= '0;
                        err_seen_q <= 1'b0;
                        first_q    <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (sample) begin
                        err_cnt_q <= err_cnt_d;
                        if (miss && !err_seen_q) begin
                            err_seen_q <= 1'b1;
                            first_q    <= vec_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            // vec_out keeps the last vector while the result is held.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                        end else begin
                            idx_q  <= idx_d;
                            hold_q <= '0;
                            vec_q  <= vec_d;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign vec_out       = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_cnt_q;
    assign err_seen      = err_seen_q;
    assign first_err_idx = first_q;
    assign mism          = mism_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;
    localparam logic [15:0] EXP   = 16'hA5F0;
    localparam int          HOLDV = 20;
    localparam int          NSTEP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: defaults except EXPECTED
    logic        start = 1'b0;
    logic [15:0] resp  = 16'h0000;
    logic [3:0]  vec_out;
    logic        f_in;
    logic        busy, done, pass, err_seen, mism;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;

    // f_in comes from a lookup table standing in for the block under test
    assign f_in = resp[vec_out];

    truth_table_sweeper #(.N_IN(4), .HOLD(HOLDV), .EXPECTED(EXP)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec_out), .f_in(f_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_seen(err_seen), .first_err_idx(first_err_idx), .mism(mism)
    );

    // small instance: N_IN=2, HOLD=1, XOR block under test
    logic       s_start = 1'b0;
    logic [1:0] s_vec;
    logic       s_f;
    logic       s_busy, s_done, s_pass, s_seen, s_mism;
    logic [2:0] s_cnt;
    logic [1:0] s_first;

    assign s_f = s_vec[1] ^ s_vec[0];

    truth_table_sweeper #(.N_IN(2), .HOLD(1), .EXPECTED(16'h0006)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .vec_out(s_vec), .f_in(s_f),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_cnt),
        .err_seen(s_seen), .first_err_idx(s_first), .mism(s_mism)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vector driven at step k of a sweep.
    function automatic int ord(input int k);
`ifdef SWEEP_GRAY_EN
        return k ^ (k >> 1);
`else
        return k;
`endif
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".vec"},   32'(vec_out), 0);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".done"},  32'(done), 0);
        chk({tag, ".pass"},  32'(pass), 0);
        chk({tag, ".cnt"},   32'(err_count), 0);
        chk({tag, ".seen"},  32'(err_seen), 0);
        chk({tag, ".first"}, 32'(first_err_idx), 0);
        chk({tag, ".mism"},  32'(mism), 0);
    endtask

    // One sweep of the main instance with response table r.
    // poke_c: clock (after the start edge) at which start is re-pulsed while busy; -1 = never.
    // abort_c: clock at which rst is pulsed between edges; -1 = never.
    task automatic run_sweep(input string tag, input logic [15:0] r, input int poke_c, input int abort_c);
        bit mis[NSTEP];
        int prefix[NSTEP+1];
        int first_v;
        int total;
        int k;
        int exp_mism;
        resp    = r;
        first_v = -1;
        prefix[0] = 0;
        for (int i = 0; i < NSTEP; i++) begin
            mis[i]      = (r[ord(i)] != EXP[ord(i)]);
            prefix[i+1] = prefix[i] + int'(mis[i]);
            if (mis[i] && first_v < 0) first_v = ord(i);
        end
        total = prefix[NSTEP];

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, ".c0.vec"},  32'(vec_out), 32'(ord(0)));
        chk({tag, ".c0.busy"}, 32'(busy), 1);
        chk({tag, ".c0.done"}, 32'(done), 0);
        chk({tag, ".c0.cnt"},  32'(err_count), 0);
        chk({tag, ".c0.seen"}, 32'(err_seen), 0);

        for (int c = 1; c <= NSTEP*HOLDV; c++) begin
            @(negedge clk);
            if (c == abort_c) begin
                #2 rst = 1'b1;
                #1 chk_zero({tag, ".abort"});
                @(negedge clk) rst = 1'b0;
                return;
            end
            k        = c / HOLDV;
            exp_mism = (c % HOLDV == 0) ? int'(mis[k-1]) : 0;
            chk({tag, ".vec"},  32'(vec_out), 32'(ord(k < NSTEP ? k : NSTEP-1)));
            chk({tag, ".cnt"},  32'(err_count), 32'(prefix[k]));
            chk({tag, ".mism"}, 32'(mism), 32'(exp_mism));
            chk({tag, ".done"}, 32'(done), 32'(c == NSTEP*HOLDV));
            chk({tag, ".busy"}, 32'(busy), 32'(c != NSTEP*HOLDV));
            chk({tag, ".pass"}, 32'(pass), 32'(c == NSTEP*HOLDV && total == 0));
            start = (c == poke_c);
        end
        start = 1'b0;
        chk({tag, ".end.seen"}, 32'(err_seen), 32'(total != 0));
        if (total != 0) chk({tag, ".end.first"}, 32'(first_err_idx), 32'(first_v));
        // outputs stay put while idle in DONE
        repeat (5) @(negedge clk);
        chk({tag, ".hold.done"}, 32'(done), 1);
        chk({tag, ".hold.cnt"},  32'(err_count), 32'(total));
        chk({tag, ".hold.vec"},  32'(vec_out), 32'(ord(NSTEP-1)));
    endtask

    logic [15:0] r16;

    initial begin
        #12;
        chk_zero("reset");
        chk("reset.small_vec", 32'(s_vec), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        run_sweep("ideal", EXP, -1, -1);
        run_sweep("tied0", 16'h0000, -1, -1);
        r16 = 16'($urandom);
        run_sweep("rand_poke", r16, 3*HOLDV + 5, -1);
        r16 = 16'($urandom);
        run_sweep("abort", r16, -1, 7*HOLDV + 3);
        chk_zero("after_abort");
        run_sweep("restart", EXP, -1, -1);
        run_sweep("tied1", 16'hFFFF, -1, -1);
        for (int n = 0; n < 3; n++) begin
            r16 = EXP ^ (16'($urandom) & 16'($urandom));
            run_sweep("rand", r16, -1, -1);
        end

        // small instance: a new vector every clock, done after 4 clocks
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        chk("small.c0.vec",  32'(s_vec), 32'(ord(0)));
        chk("small.c0.busy", 32'(s_busy), 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("small.vec",  32'(s_vec), 32'(ord(c < 4 ? c : 3)));
            chk("small.done", 32'(s_done), 32'(c == 4));
            chk("small.mism", 32'(s_mism), 0);
        end
        chk("small.pass", 32'(s_pass), 1);
        chk("small.cnt",  32'(s_cnt), 0);
        chk("small.seen", 32'(s_seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard stop in case the sequence above stalls
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
